exe_stage: RTL and testbench
============================

Name: exe_stage

Overview:
- Execute stage of the 5-stage pipeline. Sits directly downstream of the ID/EXE pipeline register and upstream of the EXE/MEM register.
- Consumes the decoded operands and control from ID/EXE. Produces the ALU result, branch decision and target, and pass-through control for MEM.
- Hosts an iterative shift-add multiplier. While it runs, the block stalls the upstream stages and injects bubbles downstream.

Parameters:
- MUL_BITS_PER_CYCLE, 1, multiplier bits retired per BUSY cycle. Legal values: 1, 2, 4. BUSY lasts 32/MUL_BITS_PER_CYCLE cycles.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- pc_in  in  32  PC of instruction in EXE
- wb_en  in  1  write-back enable
- mem_read  in  1  load
- mem_write  in  1  store
- br  in  2  branch type: 00 none, 01 BEZ, 10 BNE, 11 JMP
- exe_cmd  in  4  operation code
- data1  in  32  operand A
- data2  in  32  operand B / sign-extended immediate
- reg2  in  32  rt register value (store data, BNE compare)
- dest  in  5  destination register
- alu_result  out  32  result; also the memory address
- reg2_out  out  32  reg2 passed through
- dest_out  out  5  dest passed through
- wb_en_out  out  1  gated write-back enable
- mem_read_out  out  1  gated load enable
- mem_write_out  out  1  gated store enable
- br_taken  out  1  branch/jump taken
- br_addr  out  32  branch target
- stall  out  1  hold PC, IF/ID and ID/EXE

Behaviour:
- Interface: reset rst, asynchronous, active-high; clock clk.
- exe_cmd encoding:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 NOR, 5 XOR
  - 6 SLL, 7 SRA, 8 SRL; shift amount is data2[4:0], data1 is shifted
  - 9 MUL (low 32 bits of the unsigned 64-bit product)
  - 10 MULH (see Optional Feature)
  - 11-15 undefined: result 0, no stall
- Single-cycle ops are combinational, with 0 cycles of added latency. All arithmetic is mod 2^32.
- br_addr = pc_in + (data2 << 2), combinational, always driven.
- br_taken:
  - BEZ: taken when data1 == 0.
  - BNE: taken when data1 != reg2.
  - JMP: always taken.
  - Forced 0 while stall = 1.
- FSM states: IDLE, BUSY, DONE.
  - IDLE with exe_cmd = MUL (or MULH when enabled): stall = 1 combinationally; latch data1/data2; clear product and counter; next state BUSY.
  - BUSY: each cycle adds the shifted multiplicand for MUL_BITS_PER_CYCLE multiplier bits; stall = 1. After the final step, next state DONE.
  - DONE: stall = 0; alu_result is the selected product word; next state IDLE unconditionally.
- Stall length is 1 + 32/MUL_BITS_PER_CYCLE cycles (33 cycles at default). The result is valid for exactly one cycle, the DONE cycle, which EXE/MEM captures.
- Back-to-back MUL: DONE→IDLE coincides with ID/EXE advancing, so the next MUL starts fresh in the following IDLE cycle.
- While stall = 1: wb_en_out, mem_read_out and mem_write_out are 0, so EXE/MEM captures a bubble. alu_result is don't-care but is driven 0.
- While stall = 0: control outputs equal their inputs.
- reg2_out and dest_out always pass through.
- Reset: state IDLE, counter 0, product/operand registers 0.
  - With the zeroed ID/EXE inputs, all outputs read 0.
  - stall and br_taken are forced 0 while rst is high.
- Reset mid-BUSY: state returns to IDLE immediately, stall drops the same cycle, the partial product is discarded, and no result is produced.

Optional Feature:
- Macro EXE_MULH_EN.
- Defined: exe_cmd 10 = MULH, returning the high 32 bits of the unsigned 64-bit product, with FSM and timing identical to MUL. The product register is 64 bits.
- Undefined: exe_cmd 10 is undefined (result 0, no stall). Only a 32-bit product accumulator is kept.

Test Plan:
- Reset then idle inputs → alu_result = 0, stall = 0, br_taken = 0, wb_en_out = 0.
- ALU ops:
  - SUB data1 = 5, data2 = 7 → alu_result = 0xFFFFFFFE same cycle.
  - SRA data1 = 0x80000000, data2 = 4 → 0xF8000000.
  - SRL on the same operands → 0x08000000.
- BEZ with data1 = 0, pc_in = 0x100, data2 = 3 → br_taken = 1, br_addr = 0x10C.
  - BNE with data1 = reg2 = 9 → br_taken = 0.
- MUL 7 × 6, wb_en = 1, default parameter:
  - stall high for exactly 33 cycles, wb_en_out = 0 throughout.
  - DONE cycle: alu_result = 42, wb_en_out = 1.
  - Repeat with MUL_BITS_PER_CYCLE = 4 → stall for 9 cycles.
- Assert rst during BUSY cycle 10 of a MUL → stall = 0 in the same cycle. After release, state is IDLE and no stale product appears on alu_result.
- With EXE_MULH_EN: MULH 0xFFFFFFFF × 0xFFFFFFFF → alu_result = 0xFFFFFFFE in DONE; MUL on the same operands → 0x00000001.
  - Without the macro: cmd 10 → result 0, stall never asserted.

Source files
------------

// File: rtl/exe_stage.sv
// rtl/exe_stage.sv - EXE stage: ALU, branch resolve, iterative shift-add multiplier.
// Define EXE_MULH_EN to add MULH (exe_cmd 10, high word of the 64-bit product).
module exe_stage #(
  parameter int MUL_BITS_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_in,
  input  logic        wb_en,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  br,
  input  logic [3:0]  exe_cmd,
  input  logic [31:0] data1,
  input  logic [31:0] data2,
  input  logic [31:0] reg2,
  input  logic [4:0]  dest,
  output logic [31:0] alu_result,
  output logic [31:0] reg2_out,
  output logic [4:0]  dest_out,
  output logic        wb_en_out,
  output logic        mem_read_out,
  output logic        mem_write_out,
  output logic        br_taken,
  output logic [31:0] br_addr,
  output logic        stall
);

  localparam int         STEPS     = 32 / MUL_BITS_PER_CYCLE;
  localparam logic [4:0] LAST_STEP = 5'(STEPS - 1);
`ifdef EXE_MULH_EN
  localparam int PW = 64;
`else
  localparam int PW = 32;
`endif

  localparam logic [3:0] CMD_ADD  = 4'd0;
  localparam logic [3:0] CMD_SUB  = 4'd1;
  localparam logic [3:0] CMD_AND  = 4'd2;
  localparam logic [3:0] CMD_OR   = 4'd3;
  localparam logic [3:0] CMD_NOR  = 4'd4;
  localparam logic [3:0] CMD_XOR  = 4'd5;
  localparam logic [3:0] CMD_SLL  = 4'd6;
  localparam logic [3:0] CMD_SRA  = 4'd7;
  localparam logic [3:0] CMD_SRL  = 4'd8;
  localparam logic [3:0] CMD_MUL  = 4'd9;
`ifdef EXE_MULH_EN
  localparam logic [3:0] CMD_MULH = 4'd10;
`endif

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t        state_q, state_d;
  logic [4:0]    cnt_q, cnt_d;
  logic [PW-1:0] prod_q, prod_d;
  logic [PW-1:0] mcand_q, mcand_d;
  logic [31:0]   mplier_q, mplier_d;
`ifdef EXE_MULH_EN
  logic          hi_q, hi_d;
`endif

  logic          is_mul;
  logic [PW-1:0] partial;
  logic [31:0]   alu_comb;
  logic [31:0]   prod_word;

  always_comb begin
    is_mul = (exe_cmd == CMD_MUL);
`ifdef EXE_MULH_EN
    if (exe_cmd == CMD_MULH) is_mul = 1'b1;
`endif
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    prod_d   = prod_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
`ifdef EXE_MULH_EN
    hi_d     = hi_q;
`endif
    partial  = '0;
    for (int j = 0; j < MUL_BITS_PER_CYCLE; j++) begin
      if (mplier_q[j]) partial = partial + (mcand_q << j);
    end
    case (state_q)
      IDLE: begin
        if (is_mul) begin
          state_d  = BUSY;
          cnt_d    = '0;
          prod_d   = '0;
          mcand_d  = PW'(data1);
          mplier_d = data2;
`ifdef EXE_MULH_EN
          hi_d     = (exe_cmd == CMD_MULH);
`endif
        end
      end
      BUSY: begin
        // Multiplicand moves left and multiplier right so the low bits always select.
        prod_d   = prod_q + partial;
        mcand_d  = mcand_q << MUL_BITS_PER_CYCLE;
        mplier_d = mplier_q >> MUL_BITS_PER_CYCLE;
        cnt_d    = cnt_q + 5'd1;
        if (cnt_q == LAST_STEP) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      prod_q   <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
`ifdef EXE_MULH_EN
      hi_q     <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      prod_q   <= prod_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
`ifdef EXE_MULH_EN
      hi_q     <= hi_d;
`endif
    end
  end

  always_comb begin
`ifdef EXE_MULH_EN
    prod_word = hi_q ? prod_q[63:32] : prod_q[31:0];
`else
    prod_word = prod_q;
`endif
  end

  always_comb begin
    alu_comb = '0;
    case (exe_cmd)
      CMD_ADD: alu_comb = data1 + data2;
      CMD_SUB: alu_comb = data1 - data2;
      CMD_AND: alu_comb = data1 & data2;
      CMD_OR:  alu_comb = data1 | data2;
      CMD_NOR: alu_comb = ~(data1 | data2);
      CMD_XOR: alu_comb = data1 ^ data2;
      CMD_SLL: alu_comb = data1 << data2[4:0];
      CMD_SRA: alu_comb = $unsigned($signed(data1) >>> data2[4:0]);
      CMD_SRL: alu_comb = data1 >> data2[4:0];
      default: alu_comb = '0;
    endcase
  end

  always_comb begin
    // The IDLE-cycle stall must be combinational so ID/EXE holds the MUL it just presented.
    stall = ~rst & (((state_q == IDLE) & is_mul) | (state_q == BUSY));

    if (stall)                 alu_result = '0;
    else if (state_q == DONE)  alu_result = prod_word;
    else                       alu_result = alu_comb;

    wb_en_out     = wb_en & ~stall;
    mem_read_out  = mem_read & ~stall;
    mem_write_out = mem_write & ~stall;
    reg2_out      = reg2;
    dest_out      = dest;
    br_addr       = pc_in + (data2 << 2);

    case (br)
      2'b01:   br_taken = (data1 == 32'd0);
      2'b10:   br_taken = (data1 != reg2);
      2'b11:   br_taken = 1'b1;
      default: br_taken = 1'b0;
    endcase
    if (stall | rst) br_taken = 1'b0;
  end

endmodule

// File: tb/tb_exe_stage.sv
// tb/tb_exe_stage.sv - Directed self-checking bench for exe_stage (default and 4-bit/cycle builds).
module tb_exe_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_in, data1, data2, reg2;
  logic        wb_en, mem_read, mem_write;
  logic [1:0]  br;
  logic [3:0]  exe_cmd, exe_cmd4;
  logic [4:0]  dest;

  logic [31:0] alu_result, reg2_out, br_addr;
  logic [4:0]  dest_out;
  logic        wb_en_out, mem_read_out, mem_write_out, br_taken, stall;

  logic [31:0] alu_result4, reg2_out4, br_addr4;
  logic [4:0]  dest_out4;
  logic        wb_en_out4, mem_read_out4, mem_write_out4, br_taken4, stall4;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  exe_stage #(.MUL_BITS_PER_CYCLE(1)) dut (
    .clk(clk), .rst(rst), .pc_in(pc_in), .wb_en(wb_en), .mem_read(mem_read),
    .mem_write(mem_write), .br(br), .exe_cmd(exe_cmd), .data1(data1), .data2(data2),
    .reg2(reg2), .dest(dest), .alu_result(alu_result), .reg2_out(reg2_out),
    .dest_out(dest_out), .wb_en_out(wb_en_out), .mem_read_out(mem_read_out),
    .mem_write_out(mem_write_out), .br_taken(br_taken), .br_addr(br_addr), .stall(stall)
  );

  exe_stage #(.MUL_BITS_PER_CYCLE(4)) dut4 (
    .clk(clk), .rst(rst), .pc_in(pc_in), .wb_en(wb_en), .mem_read(mem_read),
    .mem_write(mem_write), .br(br), .exe_cmd(exe_cmd4), .data1(data1), .data2(data2),
    .reg2(reg2), .dest(dest), .alu_result(alu_result4), .reg2_out(reg2_out4),
    .dest_out(dest_out4), .wb_en_out(wb_en_out4), .mem_read_out(mem_read_out4),
    .mem_write_out(mem_write_out4), .br_taken(br_taken4), .br_addr(br_addr4), .stall(stall4)
  );

  task automatic set_idle();
    pc_in = '0; data1 = '0; data2 = '0; reg2 = '0; dest = '0;
    wb_en = 1'b0; mem_read = 1'b0; mem_write = 1'b0; br = 2'b00;
    exe_cmd = 4'd0; exe_cmd4 = 4'd0;
  endtask

  task automatic go_idle();
    @(negedge clk);
    set_idle();
  endtask

  // Presents one multiply and measures it; checks are made by the callers.
  task automatic run_mul(input bit use4, input logic [3:0] cmd, input logic [31:0] a,
                         input logic [31:0] b, output int len, output logic [31:0] res,
                         output logic wb_done, output int leaks);
    @(negedge clk);
    data1 = a; data2 = b; wb_en = 1'b1; mem_read = 1'b1; mem_write = 1'b1;
    br = 2'b00; reg2 = 32'h0; dest = 5'd3;
    if (use4) begin exe_cmd = 4'd0; exe_cmd4 = cmd; end
    else      begin exe_cmd = cmd;  exe_cmd4 = 4'd0; end
    #1;
    len = 0;
    leaks = 0;
    while ((use4 ? stall4 : stall) === 1'b1 && len < 200) begin
      len++;
      if (use4) begin
        if (wb_en_out4 !== 1'b0 || mem_read_out4 !== 1'b0 || mem_write_out4 !== 1'b0 ||
            alu_result4 !== 32'h0) leaks++;
      end else begin
        if (wb_en_out !== 1'b0 || mem_read_out !== 1'b0 || mem_write_out !== 1'b0 ||
            alu_result !== 32'h0) leaks++;
      end
      @(negedge clk);
      #1;
    end
    res     = use4 ? alu_result4 : alu_result;
    wb_done = use4 ? wb_en_out4 : wb_en_out;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_idle();
    repeat (2) @(negedge clk);
    #1;
    tests++; if (alu_result !== 32'h0) begin fails++; $display("FAIL reset_alu: got %h expected %h", alu_result, 32'h0); end
    tests++; if (stall !== 1'b0) begin fails++; $display("FAIL reset_stall: got %b expected 0", stall); end
    tests++; if (br_taken !== 1'b0) begin fails++; $display("FAIL reset_br_taken: got %b expected 0", br_taken); end
    tests++; if (wb_en_out !== 1'b0) begin fails++; $display("FAIL reset_wb_en_out: got %b expected 0", wb_en_out); end
    tests++; if (br_addr !== 32'h0) begin fails++; $display("FAIL reset_br_addr: got %h expected %h", br_addr, 32'h0); end
    exe_cmd = 4'd9; br = 2'b11;
    #1;
    tests++; if (stall !== 1'b0) begin fails++; $display("FAIL reset_forces_stall: got %b expected 0", stall); end
    tests++; if (br_taken !== 1'b0) begin fails++; $display("FAIL reset_forces_br: got %b expected 0", br_taken); end
    @(negedge clk);
    set_idle();
    rst = 1'b0;
    #1;
    tests++; if (stall !== 1'b0 || alu_result !== 32'h0) begin fails++; $display("FAIL post_reset_idle: got stall %b alu %h expected 0 0", stall, alu_result); end
  endtask

  task automatic test_alu();
    logic [3:0]  cmd [12] = '{4'd1, 4'd7, 4'd8, 4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd11, 4'd15};
    logic [31:0] a   [12] = '{32'd5, 32'h80000000, 32'h80000000, 32'hFFFFFFFF, 32'hF0F01234,
                              32'hF0000001, 32'hF0F00000, 32'hAAAA5555, 32'h00000003, 32'h80000000,
                              32'h12345678, 32'h12345678};
    logic [31:0] b   [12] = '{32'd7, 32'd4, 32'd4, 32'd2, 32'h0FF0FF00, 32'h00000F00, 32'h0F0F0000,
                              32'hFFFF0000, 32'd33, 32'd31, 32'h1, 32'h1};
    logic [31:0] exp [12] = '{32'hFFFFFFFE, 32'hF8000000, 32'h08000000, 32'h00000001, 32'h00F01200,
                              32'hF0000F01, 32'h0000FFFF, 32'h55555555, 32'h00000006, 32'h00000001,
                              32'h0, 32'h0};
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      exe_cmd = cmd[i]; data1 = a[i]; data2 = b[i]; wb_en = 1'b1;
      #1;
      tests++; if (alu_result !== exp[i]) begin fails++; $display("FAIL alu_cmd%0d_vec%0d: got %h expected %h", cmd[i], i, alu_result, exp[i]); end
      tests++; if (stall !== 1'b0 || wb_en_out !== 1'b1) begin fails++; $display("FAIL alu_nostall_vec%0d: got stall %b wb %b expected 0 1", i, stall, wb_en_out); end
    end
    go_idle();
  endtask

  task automatic test_passthrough();
    @(negedge clk);
    wb_en = 1'b1; mem_read = 1'b1; mem_write = 1'b0; reg2 = 32'hDEADBEEF; dest = 5'd17;
    #1;
    tests++; if (reg2_out !== 32'hDEADBEEF) begin fails++; $display("FAIL pass_reg2: got %h expected %h", reg2_out, 32'hDEADBEEF); end
    tests++; if (dest_out !== 5'd17) begin fails++; $display("FAIL pass_dest: got %0d expected 17", dest_out); end
    tests++; if ({wb_en_out, mem_read_out, mem_write_out} !== 3'b110) begin fails++; $display("FAIL pass_ctrl: got %b expected 110", {wb_en_out, mem_read_out, mem_write_out}); end
    go_idle();
  endtask

  task automatic test_branch();
    logic [1:0]  vb  [7] = '{2'b01, 2'b01, 2'b10, 2'b10, 2'b11, 2'b00, 2'b11};
    logic [31:0] vpc [7] = '{32'h100, 32'h100, 32'h200, 32'h200, 32'h300, 32'h400, 32'h100};
    logic [31:0] vd1 [7] = '{32'd0, 32'd1, 32'd9, 32'd9, 32'd5, 32'd0, 32'd0};
    logic [31:0] vd2 [7] = '{32'd3, 32'd3, 32'd1, 32'd1, 32'd4, 32'd0, 32'hFFFFFFFE};
    logic [31:0] vr2 [7] = '{32'd0, 32'd0, 32'd9, 32'd8, 32'd0, 32'd0, 32'd0};
    logic        vtk [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [31:0] vad [7] = '{32'h10C, 32'h10C, 32'h204, 32'h204, 32'h310, 32'h400, 32'hF8};
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      br = vb[i]; pc_in = vpc[i]; data1 = vd1[i]; data2 = vd2[i]; reg2 = vr2[i];
      #1;
      tests++; if (br_taken !== vtk[i]) begin fails++; $display("FAIL br_taken_vec%0d: got %b expected %b", i, br_taken, vtk[i]); end
      tests++; if (br_addr !== vad[i]) begin fails++; $display("FAIL br_addr_vec%0d: got %h expected %h", i, br_addr, vad[i]); end
    end
    go_idle();
  endtask

  task automatic test_branch_stall();
    @(negedge clk);
    exe_cmd = 4'd9; br = 2'b11; pc_in = 32'h40; data1 = 32'd2; data2 = 32'd3;
    #1;
    tests++; if (stall !== 1'b1) begin fails++; $display("FAIL brstall_stall: got %b expected 1", stall); end
    tests++; if (br_taken !== 1'b0) begin fails++; $display("FAIL brstall_taken: got %b expected 0", br_taken); end
    tests++; if (br_addr !== 32'h4C) begin fails++; $display("FAIL brstall_addr: got %h expected %h", br_addr, 32'h4C); end
    rst = 1'b1;
    #1;
    tests++; if (br_taken !== 1'b0 || stall !== 1'b0) begin fails++; $display("FAIL brstall_rst: got taken %b stall %b expected 0 0", br_taken, stall); end
    @(negedge clk);
    set_idle();
    rst = 1'b0;
  endtask

  task automatic test_mul();
    int len, leaks;
    logic [31:0] res;
    logic wbd;
    run_mul(1'b0, 4'd9, 32'd7, 32'd6, len, res, wbd, leaks);
    tests++; if (len !== 33) begin fails++; $display("FAIL mul_stall_len: got %0d expected 33", len); end
    tests++; if (leaks !== 0) begin fails++; $display("FAIL mul_bubble: got %0d leaking cycles expected 0", leaks); end
    tests++; if (res !== 32'd42) begin fails++; $display("FAIL mul_result: got %h expected %h", res, 32'd42); end
    tests++; if (wbd !== 1'b1) begin fails++; $display("FAIL mul_done_wb: got %b expected 1", wbd); end
    go_idle();
  endtask

  task automatic test_mul_wide4();
    int len, leaks;
    logic [31:0] res;
    logic wbd;
    run_mul(1'b1, 4'd9, 32'd7, 32'd6, len, res, wbd, leaks);
    tests++; if (len !== 9) begin fails++; $display("FAIL mul4_stall_len: got %0d expected 9", len); end
    tests++; if (res !== 32'd42 || wbd !== 1'b1 || leaks !== 0) begin fails++; $display("FAIL mul4_result: got %h wb %b leaks %0d expected %h 1 0", res, wbd, leaks, 32'd42); end
    go_idle();
    run_mul(1'b1, 4'd9, 32'h0000FFFF, 32'h00010001, len, res, wbd, leaks);
    tests++; if (res !== 32'hFFFFFFFF || len !== 9) begin fails++; $display("FAIL mul4_wide: got %h len %0d expected %h 9", res, len, 32'hFFFFFFFF); end
    go_idle();
  endtask

  task automatic test_back_to_back();
    int len, leaks;
    logic [31:0] res;
    logic wbd;
    run_mul(1'b0, 4'd9, 32'd7, 32'd6, len, res, wbd, leaks);
    tests++; if (res !== 32'd42) begin fails++; $display("FAIL b2b_first: got %h expected %h", res, 32'd42); end
    run_mul(1'b0, 4'd9, 32'h0000FFFF, 32'h00010001, len, res, wbd, leaks);
    tests++; if (len !== 33) begin fails++; $display("FAIL b2b_second_len: got %0d expected 33", len); end
    tests++; if (res !== 32'hFFFFFFFF) begin fails++; $display("FAIL b2b_second_result: got %h expected %h", res, 32'hFFFFFFFF); end
    go_idle();
  endtask

  task automatic test_mulh();
    int len, leaks;
    logic [31:0] res;
    logic wbd;
`ifdef EXE_MULH_EN
    run_mul(1'b0, 4'd10, 32'hFFFFFFFF, 32'hFFFFFFFF, len, res, wbd, leaks);
    tests++; if (res !== 32'hFFFFFFFE || len !== 33) begin fails++; $display("FAIL mulh_result: got %h len %0d expected %h 33", res, len, 32'hFFFFFFFE); end
    go_idle();
    run_mul(1'b1, 4'd10, 32'h00010000, 32'h00010000, len, res, wbd, leaks);
    tests++; if (res !== 32'h00000001 || len !== 9) begin fails++; $display("FAIL mulh4_result: got %h len %0d expected %h 9", res, len, 32'h1); end
    go_idle();
`else
    int bad;
    @(negedge clk);
    exe_cmd = 4'd10; data1 = 32'hFFFFFFFF; data2 = 32'hFFFFFFFF; wb_en = 1'b1;
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (stall !== 1'b0 || alu_result !== 32'h0 || wb_en_out !== 1'b1) bad++;
      @(negedge clk);
    end
    tests++; if (bad !== 0) begin fails++; $display("FAIL cmd10_undefined: got %0d bad cycles expected 0", bad); end
    go_idle();
`endif
    run_mul(1'b0, 4'd9, 32'hFFFFFFFF, 32'hFFFFFFFF, len, res, wbd, leaks);
    tests++; if (res !== 32'h00000001) begin fails++; $display("FAIL mul_low_ones: got %h expected %h", res, 32'h1); end
    go_idle();
  endtask

  task automatic test_reset_busy();
    int bad;
    @(negedge clk);
    exe_cmd = 4'd9; data1 = 32'd7; data2 = 32'd6; wb_en = 1'b1;
    #1;
    tests++; if (stall !== 1'b1) begin fails++; $display("FAIL rbusy_idle_stall: got %b expected 1", stall); end
    repeat (10) @(negedge clk);
    #1;
    tests++; if (stall !== 1'b1) begin fails++; $display("FAIL rbusy_busy10_stall: got %b expected 1", stall); end
    rst = 1'b1;
    #1;
    tests++; if (stall !== 1'b0) begin fails++; $display("FAIL rbusy_stall_drop: got %b expected 0", stall); end
    @(negedge clk);
    set_idle();
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (stall !== 1'b0 || alu_result !== 32'h0) bad++;
      @(negedge clk);
    end
    tests++; if (bad !== 0) begin fails++; $display("FAIL rbusy_no_stale: got %0d bad cycles expected 0", bad); end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_passthrough();
    test_branch();
    test_branch_stall();
    test_mul();
    test_mul_wide4();
    test_back_to_back();
    test_mulh();
    test_reset_busy();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
